// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial pattern transmitter, MSB-first, one-shot or repeat with gap
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [GAP_W-1:0] gap_in,
    input  logic             start,
    input  logic             repeat_en,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    localparam logic [LEN_W-1:0] C_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [GAP_W-1:0] C_GAP_ONE  = GAP_W'(1);
    localparam logic [PAT_W-1:0] C_PAT_ONE  = PAT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [PAT_W-1:0]   r_pat, w_pat;
    logic [LEN_W-1:0]   r_len, w_len;
    logic [GAP_W-1:0]   r_gap, w_gap;
    logic [LEN_W-1:0]   r_idx, w_idx;
    logic [GAP_W-1:0]   r_gcnt, w_gcnt;
    logic               r_dout, w_dout;
    logic               r_valid, w_valid;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_load_err, w_load_err;

    logic [LEN_W-1:0]   w_len_m1;
    logic [LEN_W-1:0]   w_idx_m1;
    logic               w_first_bit;
    logic               w_next_bit;
    logic               w_len_ok;

    assign w_len_m1    = r_len - C_LEN_ONE;
    assign w_idx_m1    = r_idx - C_LEN_ONE;
    // Bit selects done by masking so the index width need not match $clog2(PAT_W)
    assign w_first_bit = |(r_pat & (C_PAT_ONE << w_len_m1));
    assign w_next_bit  = |(r_pat & (C_PAT_ONE << w_idx_m1));
    assign w_len_ok    = (len_in != '0) && (len_in <= C_LEN_MAX);

    always_comb begin
        w_state    = r_state;
        w_pat      = r_pat;
        w_len      = r_len;
        w_gap      = r_gap;
        w_idx      = r_idx;
        w_gcnt     = r_gcnt;
        w_dout     = 1'b0;
        w_valid    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_load_err = 1'b0;

        case (r_state)
            IDLE: begin
                if (load) begin
                    if (w_len_ok) begin
                        w_pat = pat_in;
                        w_len = len_in;
                        w_gap = gap_in;
                    end else begin
                        w_load_err = 1'b1;
                    end
                end else if (start && (r_len != '0)) begin
                    w_state = SHIFT;
                    w_idx   = w_len_m1;
                    w_dout  = w_first_bit;
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                end
            end

            SHIFT: begin
                if (abort) begin
                    w_state = IDLE;
                end else if (r_idx != '0) begin
                    w_idx   = w_idx_m1;
                    w_dout  = w_next_bit;
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                end else if (repeat_en) begin
                    w_busy = 1'b1;
                    if (r_gap == '0) begin
                        w_idx   = w_len_m1;
                        w_dout  = w_first_bit;
                        w_valid = 1'b1;
                    end else begin
                        w_state = GAP;
                        w_gcnt  = r_gap;
                    end
                end else begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end
            end

            GAP: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                end else if (r_gcnt <= C_GAP_ONE) begin
                    // Last idle cycle: the next cycle already carries the MSB
                    w_state = SHIFT;
                    w_idx   = w_len_m1;
                    w_dout  = w_first_bit;
                    w_valid = 1'b1;
                end else begin
                    w_gcnt = r_gcnt - C_GAP_ONE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_len      <= '0;
            r_gap      <= '0;
            r_idx      <= '0;
            r_gcnt     <= '0;
            r_dout     <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pat      <= w_pat;
            r_len      <= w_len;
            r_gap      <= w_gap;
            r_idx      <= w_idx;
            r_gcnt     <= w_gcnt;
            r_dout     <= w_dout;
            r_valid    <= w_valid;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_load_err <= w_load_err;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_err   = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Directed self-checking bench for seq_pattern_gen
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_gen;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic [3:0] gap_in;
    logic       start;
    logic       repeat_en;
    logic       abort;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;
    logic       load_err;

    int n_tests = 0;
    int n_fail  = 0;

    seq_pattern_gen #(
        .PAT_W (8),
        .LEN_W (4),
        .GAP_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .pat_in     (pat_in),
        .len_in     (len_in),
        .gap_in     (gap_in),
        .start      (start),
        .repeat_en  (repeat_en),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the cycle currently on the outputs, then advance one cycle
    task automatic exp_cycle(input string tag, input logic v, input logic d,
                             input logic b, input logic dn);
        check({tag, "_valid"}, {31'd0, dout_valid}, {31'd0, v});
        check({tag, "_dout"},  {31'd0, dout},       {31'd0, d});
        check({tag, "_busy"},  {31'd0, busy},       {31'd0, b});
        check({tag, "_done"},  {31'd0, done},       {31'd0, dn});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ab_bits;
        rst = 1'b0; load = 1'b0; pat_in = '0; len_in = '0; gap_in = '0;
        start = 1'b0; repeat_en = 1'b0; abort = 1'b0;

        #12;
        check("rst_dout",     {31'd0, dout},       32'd0);
        check("rst_valid",    {31'd0, dout_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_done",     {31'd0, done},       32'd0);
        check("rst_load_err", {31'd0, load_err},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // start with nothing loaded
        start = 1'b1; tick(); start = 1'b0;
        check("nostart_valid", {31'd0, dout_valid}, 32'd0);
        check("nostart_busy",  {31'd0, busy},       32'd0);

        // len 0 rejected
        load = 1'b1; pat_in = 8'hFF; len_in = 4'd0; tick(); load = 1'b0;
        check("len0_err", {31'd0, load_err}, 32'd1);
        tick();
        check("len0_err_pulse", {31'd0, load_err}, 32'd0);

        // len 9 rejected
        load = 1'b1; pat_in = 8'hFF; len_in = 4'd9; tick(); load = 1'b0;
        check("len9_err", {31'd0, load_err}, 32'd1);
        tick();
        check("len9_err_pulse", {31'd0, load_err}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("after_bad_load_valid", {31'd0, dout_valid}, 32'd0);

        // load+start: stores only
        load = 1'b1; start = 1'b1; pat_in = 8'b0000_0101; len_in = 4'd3; gap_in = 4'd0;
        tick(); load = 1'b0; start = 1'b0;
        check("ldst_valid", {31'd0, dout_valid}, 32'd0);
        check("ldst_err",   {31'd0, load_err},   32'd0);
        tick();
        check("ldst_busy",  {31'd0, busy},       32'd0);

        // one-shot 1,0,1
        start = 1'b1; tick(); start = 1'b0;
        exp_cycle("os1", 1, 1, 1, 0);
        exp_cycle("os2", 1, 0, 1, 0);
        exp_cycle("os3", 1, 1, 1, 0);
        exp_cycle("os_done", 0, 0, 0, 1);
        exp_cycle("os_idle", 0, 0, 0, 0);

        // repeat gap 0, drop repeat_en in second frame's last bit
        repeat_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        exp_cycle("r0_1", 1, 1, 1, 0);
        exp_cycle("r0_2", 1, 0, 1, 0);
        exp_cycle("r0_3", 1, 1, 1, 0);
        exp_cycle("r0_4", 1, 1, 1, 0);
        exp_cycle("r0_5", 1, 0, 1, 0);
        repeat_en = 1'b0;
        exp_cycle("r0_6", 1, 1, 1, 0);
        exp_cycle("r0_done", 0, 0, 0, 1);
        exp_cycle("r0_idle", 0, 0, 0, 0);

        // repeat with gap 2; a load during GAP must be ignored silently
        load = 1'b1; pat_in = 8'b0000_0101; len_in = 4'd3; gap_in = 4'd2;
        tick(); load = 1'b0;
        repeat_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        exp_cycle("g2_1", 1, 1, 1, 0);
        exp_cycle("g2_2", 1, 0, 1, 0);
        exp_cycle("g2_3", 1, 1, 1, 0);
        load = 1'b1; len_in = 4'd0;
        exp_cycle("g2_gap1", 0, 0, 1, 0);
        load = 1'b0;
        check("busy_load_no_err", {31'd0, load_err}, 32'd0);
        exp_cycle("g2_gap2", 0, 0, 1, 0);
        exp_cycle("g2_4", 1, 1, 1, 0);
        exp_cycle("g2_5", 1, 0, 1, 0);
        repeat_en = 1'b0;
        exp_cycle("g2_6", 1, 1, 1, 0);
        exp_cycle("g2_done", 0, 0, 0, 1);

        // abort on the 2nd bit of 1011_0100
        load = 1'b1; pat_in = 8'b1011_0100; len_in = 4'd8; gap_in = 4'd0;
        tick(); load = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        exp_cycle("ab1", 1, 1, 1, 0);
        abort = 1'b1;
        exp_cycle("ab2", 1, 0, 1, 0);
        abort = 1'b0;
        exp_cycle("ab_stop", 0, 0, 0, 0);
        exp_cycle("ab_nodone", 0, 0, 0, 0);

        // replay full pattern from MSB
        ab_bits = 8'b1011_0100;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            exp_cycle($sformatf("replay_b%0d", i), 1, ab_bits[i], 1, 0);
        end
        exp_cycle("replay_done", 0, 0, 0, 1);

        // asynchronous reset mid-SHIFT, while dout=1
        start = 1'b1; tick(); start = 1'b0;
        check("pre_rst_dout", {31'd0, dout}, 32'd1);
        #3 rst = 1'b0;
        #1;
        check("arst_dout",  {31'd0, dout},       32'd0);
        check("arst_valid", {31'd0, dout_valid}, 32'd0);
        check("arst_busy",  {31'd0, busy},       32'd0);
        check("arst_done",  {31'd0, done},       32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("post_rst_valid", {31'd0, dout_valid}, 32'd0);
        tick();
        check("post_rst_busy",  {31'd0, busy},       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
